div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative signed divider among NUM_REQ requesters in the FM radio datapath.
- Accepts one request at a time and latches its operands. Issues a single-cycle start to the divider and holds the operands stable until it completes.
- Returns quotient, remainder, overflow and timeout status to the originating requester.
- Recovers from a hung divider with a flush pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DIVIDEND_WIDTH, 64, dividend/quotient width
- DIVISOR_WIDTH, 32, divisor/remainder width
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before abort (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held high with stable operands until req_ready
- req_ready  out  NUM_REQ  one-hot, one-cycle grant/accept pulse
- req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed dividends; requester i at slice i
- req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed divisors
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe; no backpressure
- rsp_id  out  $clog2(NUM_REQ)  index of responding requester
- rsp_quotient  out  DIVIDEND_WIDTH  result quotient
- rsp_remainder  out  DIVISOR_WIDTH  result remainder
- rsp_overflow  out  1  divisor was zero
- rsp_timeout  out  1  divider did not finish; quotient/remainder forced to 0
- div_valid_in  out  1  divider start pulse
- div_dividend  out  DIVIDEND_WIDTH  latched operand to divider
- div_divisor  out  DIVISOR_WIDTH  latched operand to divider
- div_quotient  in  DIVIDEND_WIDTH  divider quotient; valid when div_valid_out=1
- div_remainder  in  DIVISOR_WIDTH  divider remainder; combinational, valid only in the cycle before div_valid_out
- div_valid_out  in  1  divider done strobe
- div_flush  out  1  one-cycle pulse, ORed into the divider reset on abort

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; rr_ptr=0.
  - All outputs 0, including the latched operands, counters and result registers.
  - Reset mid-transaction drops the transaction silently: no rsp_valid. Divider operands go to 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first asserted index g wins.
  - Same cycle: req_ready[g]=1. Latch req_dividend[g] and req_divisor[g] into the operand registers, latch id=g, then go to ISSUE.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - No requests: stay in IDLE; rr_ptr unchanged.
- ISSUE: div_valid_in=1 for exactly this cycle; timeout counter cleared; go to WAIT.
- WAIT:
  - Every cycle: register div_remainder into rem_shadow and increment the counter.
  - div_valid_out=1: capture div_quotient. Remainder comes from rem_shadow (the previous cycle's value). Overflow = (latched divisor==0). Go to RESP.
  - Counter reaches TIMEOUT_CYCLES without div_valid_out:
    - div_flush=1 for one cycle.
    - Result quotient and remainder = 0; timeout=1; overflow=0; go to RESP.
  - If div_valid_out arrives on the same cycle the counter reaches TIMEOUT_CYCLES, the completion wins and there is no flush.
- RESP:
  - rsp_valid[id]=1 and rsp_id=id for one cycle; go to IDLE.
  - rsp_quotient, rsp_remainder, rsp_overflow and rsp_timeout are registered. They hold their value until the next RESP.
- Operand stability: div_dividend and div_divisor are driven from the latched registers and change only in IDLE on a grant. They stay constant from ISSUE through RESP.
- Latency: grant cycle T; div_valid_in at T+1; rsp_valid one cycle after div_valid_out. Minimum request-to-request spacing is 4 cycles. The arbiter serves at most one request at a time.
- div_valid_out outside WAIT is ignored.
- A requester dropping req_valid before req_ready violates the protocol; no grant is guaranteed.
- A requester re-asserting req_valid in its own RESP cycle is eligible in the following IDLE, subject to rr_ptr.

Test Plan:
- Single request: requester 1, dividend=100, divisor=7 → req_ready[1] one cycle, one div_valid_in pulse, rsp_valid[1], rsp_id=1, quotient=14, remainder=2, overflow=0, timeout=0.
- Signed: requester 0, dividend=-100, divisor=7 → rsp_quotient=-14 (two's complement, 64-bit); operands stable on div_* across the whole transaction.
- Divide by zero: requester 3, dividend=55, divisor=0 → rsp_overflow=1, rsp_timeout=0, single rsp_valid[3].
- Round robin:
  - All four requesters assert from reset → grant order 0,1,2,3, each after the prior RESP.
  - Next, requesters 2 and 0 assert with rr_ptr=0 → grant 0 then 2.
  - Requester 3 alone asserts with rr_ptr=1 → granted.
- Timeout: stub divider never asserts div_valid_out, TIMEOUT_CYCLES=16 → div_flush one cycle after 16 WAIT cycles, rsp_timeout=1, quotient=0, remainder=0. The next request then completes normally.
- Reset mid-WAIT: assert reset during WAIT → no rsp_valid; all outputs 0 next cycle; rr_ptr=0; a fresh request from requester 2 completes correctly.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one iterative signed divider
// among NUM_REQ requesters. One transaction is in flight at a time; the
// operands are latched at grant and held on the divider port until the
// response goes out. A divider that never finishes is aborted with a flush.
module div_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
    output logic [DIVIDEND_WIDTH-1:0]           rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]            rsp_remainder,
    output logic                                rsp_overflow,
    output logic                                rsp_timeout,
    output logic                                div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]            div_remainder,
    input  logic                                div_valid_out,
    output logic                                div_flush
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                             r_state;
    logic [ID_W-1:0]                    r_rr_ptr;
    logic [ID_W-1:0]                    r_id;
    logic signed [DIVIDEND_WIDTH-1:0]   r_dvd;
    logic signed [DIVISOR_WIDTH-1:0]    r_dvs;
    logic [CNT_W-1:0]                   r_cnt;
    logic signed [DIVISOR_WIDTH-1:0]    r_rem_shadow;
    logic                               r_div_valid_in;
    logic                               r_flush;
    logic [NUM_REQ-1:0]                 r_rsp_valid;
    logic [ID_W-1:0]                    r_rsp_id;
    logic signed [DIVIDEND_WIDTH-1:0]   r_quo;
    logic signed [DIVISOR_WIDTH-1:0]    r_rem;
    logic                               r_ovf;
    logic                               r_tmo;

    logic                               w_found;
    logic [ID_W-1:0]                    w_gnt_idx;
    logic [ID_W:0]                      w_scan;
    logic [ID_W-1:0]                    w_next_ptr;
    logic [NUM_REQ-1:0]                 w_gnt_onehot;
    logic [NUM_REQ-1:0]                 w_id_onehot;
    logic [CNT_W-1:0]                   w_cnt_next;
    logic                               w_timeout_hit;

    logic [DIVIDEND_WIDTH-1:0]          w_dvd_arr [NUM_REQ];
    logic [DIVISOR_WIDTH-1:0]           w_dvs_arr [NUM_REQ];

    // Unpack the flat operand buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_dvd_arr[gi] = req_dividend[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        assign w_dvs_arr[gi] = req_divisor[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    end

    // Round-robin scan: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_next_ptr    = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    assign w_gnt_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_id_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_id;
    assign w_cnt_next    = r_cnt + CNT_W'(1);
    assign w_timeout_hit = (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    // The accept pulse is combinational so the requester sees it in the
    // same cycle its operands are latched; it is masked while in reset so
    // nobody believes a request was taken that the reset then discards.
    assign req_ready = (!reset && (r_state == S_IDLE) && w_found) ? w_gnt_onehot : '0;

    // Sequencer: grant, start pulse, wait with timeout, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_id           <= '0;
            r_dvd          <= '0;
            r_dvs          <= '0;
            r_cnt          <= '0;
            r_rem_shadow   <= '0;
            r_div_valid_in <= 1'b0;
            r_flush        <= 1'b0;
            r_rsp_valid    <= '0;
            r_rsp_id       <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_ovf          <= 1'b0;
            r_tmo          <= 1'b0;
        end else begin
            r_div_valid_in <= 1'b0;
            r_flush        <= 1'b0;
            r_rsp_valid    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_dvd          <= w_dvd_arr[w_gnt_idx];
                        r_dvs          <= w_dvs_arr[w_gnt_idx];
                        r_id           <= w_gnt_idx;
                        r_rr_ptr       <= w_next_ptr;
                        r_div_valid_in <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt        <= '0;
                    r_rem_shadow <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // The divider's remainder is only valid the cycle before
                    // its done strobe, so it is shadowed every cycle.
                    r_rem_shadow <= div_remainder;
                    r_cnt        <= w_cnt_next;
                    if (div_valid_out) begin
                        r_quo       <= div_quotient;
                        r_rem       <= r_rem_shadow;
                        r_ovf       <= (r_dvs == '0);
                        r_tmo       <= 1'b0;
                        r_rsp_valid <= w_id_onehot;
                        r_rsp_id    <= r_id;
                        r_state     <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_flush     <= 1'b1;
                        r_quo       <= '0;
                        r_rem       <= '0;
                        r_ovf       <= 1'b0;
                        r_tmo       <= 1'b1;
                        r_rsp_valid <= w_id_onehot;
                        r_rsp_id    <= r_id;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_valid_in  = r_div_valid_in;
    assign div_dividend  = r_dvd;
    assign div_divisor   = r_dvs;
    assign div_flush     = r_flush;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_quotient  = r_quo;
    assign rsp_remainder = r_rem;
    assign rsp_overflow  = r_ovf;
    assign rsp_timeout   = r_tmo;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural stub divider of
// programmable latency (or hung), 4 requesters and a 16-cycle timeout.
module tb_div_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int VW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_dividend;
    logic [NR*VW-1:0] req_divisor;
    logic [NR-1:0]   rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_quotient;
    logic [VW-1:0]   rsp_remainder;
    logic            rsp_overflow;
    logic            rsp_timeout;
    logic            div_valid_in;
    logic [DW-1:0]   div_dividend;
    logic [VW-1:0]   div_divisor;
    logic [DW-1:0]   div_quotient;
    logic [VW-1:0]   div_remainder;
    logic            div_valid_out;
    logic            div_flush;

    div_arbiter #(.NUM_REQ(NR), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_valid_out(div_valid_out), .div_flush(div_flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stub divider state
    int            s_lat  = 3;
    logic          s_hang = 1'b0;
    logic          s_busy = 1'b0;
    int            s_cnt  = 0;
    logic [DW-1:0] s_quo;
    logic [VW-1:0] s_rem;

    // operand tables and expected results per requester
    logic [DW-1:0] t_dvd [NR];
    logic [VW-1:0] t_dvs [NR];
    logic [DW-1:0] e_q   [NR];
    logic [VW-1:0] e_r   [NR];

    // observations from the last run_txns call
    int            m_order, m_rsp_order, m_n_rsp, m_n_start, m_n_flush;
    int            m_lat, m_start_lat, m_flush_lat, m_bad_data, m_unstable;
    int            m_busy_grant, m_ready_bad, m_spurious;
    logic          m_expired;
    logic [NR-1:0] m_rv, m_first_ready;
    logic [1:0]    m_rid;
    logic [DW-1:0] m_q;
    logic [VW-1:0] m_r;
    logic          m_ovf, m_tmo;

    // Stub divider: quotient/valid at s_lat WAIT cycles after start; the
    // remainder is only shown one cycle earlier, garbage otherwise.
    initial begin
        longint a, b;
        div_valid_out = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        forever begin
            @(negedge clk);
            div_valid_out = 1'b0;
            div_quotient  = 64'hBAD0_BAD0_BAD0_BAD0;
            div_remainder = 32'hDEAD_BEEF;
            if (div_flush === 1'b1) s_busy = 1'b0;
            if (s_busy) begin
                s_cnt++;
                if (!s_hang) begin
                    if (s_cnt == s_lat - 1) div_remainder = s_rem;
                    if (s_cnt == s_lat) begin
                        div_valid_out = 1'b1;
                        div_quotient  = s_quo;
                        s_busy        = 1'b0;
                    end
                end
            end
            if (div_valid_in === 1'b1) begin
                s_busy = 1'b1;
                s_cnt  = 0;
                a = $signed(div_dividend);
                b = longint'($signed(div_divisor));
                if (b == 0) begin
                    s_quo = '1;
                    s_rem = '0;
                end else begin
                    s_quo = a / b;
                    s_rem = VW'(a % b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_tbl(input int i, input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                           input logic [DW-1:0] q, input logic [VW-1:0] r);
        t_dvd[i] = dvd; t_dvs[i] = dvs; e_q[i] = q; e_r[i] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive the requesters in mask, drop each one after its accept, and
    // observe until n_expect responses arrive (bounded).
    task automatic run_txns(input logic [NR-1:0] mask, input int n_expect);
        logic [NR-1:0] drop;
        int cyc, g_cyc, cur;
        logic busy;
        m_order = 0; m_rsp_order = 0; m_n_rsp = 0; m_n_start = 0; m_n_flush = 0;
        m_lat = -1; m_start_lat = -1; m_flush_lat = -1; m_bad_data = 0; m_unstable = 0;
        m_busy_grant = 0; m_ready_bad = 0; m_spurious = 0; m_expired = 1'b0;
        m_first_ready = '0;
        drop = '0; busy = 1'b0; cyc = 0; g_cyc = 0; cur = 0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_dividend[i*DW +: DW] = t_dvd[i];
            req_divisor[i*VW +: VW]  = t_dvs[i];
        end
        req_valid = mask;
        while (m_n_rsp < n_expect && cyc < 200) begin
            #1;
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1) m_ready_bad++;
                if (busy) m_busy_grant++;
                if (m_first_ready == '0) m_first_ready = req_ready;
                for (int i = 0; i < NR; i++) if (req_ready[i]) cur = i;
                m_order = m_order * 10 + cur + 1;
                g_cyc = cyc; busy = 1'b1; drop = req_ready;
            end else if (busy) begin
                if (div_dividend !== t_dvd[cur] || div_divisor !== t_dvs[cur]) m_unstable++;
                if (div_valid_in) begin m_n_start++; m_start_lat = cyc - g_cyc; end
                if (div_flush) begin m_n_flush++; m_flush_lat = cyc - g_cyc; end
                if (rsp_valid != '0) begin
                    m_n_rsp++; m_lat = cyc - g_cyc; m_rv = rsp_valid; m_rid = rsp_id;
                    m_q = rsp_quotient; m_r = rsp_remainder; m_ovf = rsp_overflow; m_tmo = rsp_timeout;
                    m_rsp_order = m_rsp_order * 10 + int'(rsp_id) + 1;
                    if (rsp_valid !== (NR'(1) << cur) || int'(rsp_id) != cur ||
                        rsp_quotient !== e_q[cur] || rsp_remainder !== e_r[cur]) m_bad_data++;
                    busy = 1'b0;
                end
            end else if (div_valid_in || div_flush || rsp_valid != '0) begin
                m_spurious++;
            end
            @(negedge clk);
            cyc++;
            req_valid = req_valid & ~drop;
            drop = '0;
        end
        if (m_n_rsp < n_expect) m_expired = 1'b1;
        #1;
        if (rsp_valid != '0 || div_flush || div_valid_in) m_spurious++;
        req_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        req_dividend = {4{64'h1111_2222_3333_4444}};
        req_divisor  = {4{32'h5555_6666}};
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_checks++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_checks++; if (rsp_quotient !== 64'd0 || rsp_remainder !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%0h/%0h exp=0/0", rsp_quotient, rsp_remainder); end
        n_checks++; if (rsp_overflow !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%b%b exp=00", rsp_overflow, rsp_timeout); end
        n_checks++; if (div_valid_in !== 1'b0 || div_flush !== 1'b0) begin n_fail++; $display("FAIL reset_div_ctl got=%b%b exp=00", div_valid_in, div_flush); end
        n_checks++; if (div_dividend !== 64'd0 || div_divisor !== 32'd0) begin n_fail++; $display("FAIL reset_div_ops got=%0h/%0h exp=0/0", div_dividend, div_divisor); end
        req_valid = '0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (div_valid_in !== 1'b0 || rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_release_idle got=%b/%b exp=0/0000", div_valid_in, rsp_valid); end
    endtask

    task automatic test_single();
        set_tbl(1, 64'd100, 32'd7, 64'd14, 32'd2);
        run_txns(4'b0010, 1);
        n_checks++; if (m_expired) begin n_fail++; $display("FAIL single_done got=expired exp=response"); end
        n_checks++; if (m_first_ready !== 4'b0010 || m_order != 2) begin n_fail++; $display("FAIL single_ready got=%b order=%0d exp=0010 order=2", m_first_ready, m_order); end
        n_checks++; if (m_n_start != 1 || m_start_lat != 1) begin n_fail++; $display("FAIL single_start got=%0d@%0d exp=1@1", m_n_start, m_start_lat); end
        n_checks++; if (m_lat != 5) begin n_fail++; $display("FAIL single_latency got=%0d exp=5", m_lat); end
        n_checks++; if (m_rv !== 4'b0010 || m_rid !== 2'd1) begin n_fail++; $display("FAIL single_rsp_id got=%b/%0d exp=0010/1", m_rv, m_rid); end
        n_checks++; if (m_q !== 64'd14) begin n_fail++; $display("FAIL single_quotient got=%0d exp=14", m_q); end
        n_checks++; if (m_r !== 32'd2) begin n_fail++; $display("FAIL single_remainder got=%0h exp=2", m_r); end
        n_checks++; if (m_ovf !== 1'b0 || m_tmo !== 1'b0 || m_n_flush != 0) begin n_fail++; $display("FAIL single_status got=ovf%b tmo%b flush%0d exp=0 0 0", m_ovf, m_tmo, m_n_flush); end
        n_checks++; if (m_spurious != 0) begin n_fail++; $display("FAIL single_one_cycle got=%0d extra strobes exp=0", m_spurious); end
    endtask

    task automatic test_signed();
        set_tbl(0, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE);
        run_txns(4'b0001, 1);
        n_checks++; if (m_q !== 64'hFFFF_FFFF_FFFF_FFF2) begin n_fail++; $display("FAIL signed_quotient got=%0h exp=fffffffffffffff2", m_q); end
        n_checks++; if (m_r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL signed_remainder got=%0h exp=fffffffe", m_r); end
        n_checks++; if (m_unstable != 0) begin n_fail++; $display("FAIL signed_operand_stable got=%0d unstable cycles exp=0", m_unstable); end
        n_checks++; if (m_rv !== 4'b0001 || m_bad_data != 0) begin n_fail++; $display("FAIL signed_rsp got=%b bad=%0d exp=0001 bad=0", m_rv, m_bad_data); end
    endtask

    task automatic test_divzero();
        set_tbl(3, 64'd55, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0);
        run_txns(4'b1000, 1);
        n_checks++; if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL divzero_overflow got=%b exp=1", m_ovf); end
        n_checks++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL divzero_timeout got=%b exp=0", m_tmo); end
        n_checks++; if (m_n_rsp != 1 || m_rv !== 4'b1000 || m_spurious != 0) begin n_fail++; $display("FAIL divzero_rsp got=%0d x %b extra=%0d exp=1 x 1000 extra=0", m_n_rsp, m_rv, m_spurious); end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_tbl(0, 64'd50, 32'd3, 64'd16, 32'd2);
        set_tbl(1, 64'd60, 32'd4, 64'd15, 32'd0);
        set_tbl(2, 64'd70, 32'd5, 64'd14, 32'd0);
        set_tbl(3, 64'd80, 32'd6, 64'd13, 32'd2);
        run_txns(4'b1111, 4);
        n_checks++; if (m_order != 1234) begin n_fail++; $display("FAIL rr_all_order got=%0d exp=1234", m_order); end
        n_checks++; if (m_rsp_order != 1234 || m_bad_data != 0) begin n_fail++; $display("FAIL rr_all_rsp got=%0d bad=%0d exp=1234 bad=0", m_rsp_order, m_bad_data); end
        n_checks++; if (m_busy_grant != 0 || m_ready_bad != 0) begin n_fail++; $display("FAIL rr_serial got=busy%0d multi%0d exp=0 0", m_busy_grant, m_ready_bad); end
        n_checks++; if (m_n_start != 4 || m_unstable != 0) begin n_fail++; $display("FAIL rr_starts got=%0d unstable=%0d exp=4 0", m_n_start, m_unstable); end
        run_txns(4'b0101, 2);
        n_checks++; if (m_order != 13 || m_bad_data != 0) begin n_fail++; $display("FAIL rr_pair_order got=%0d bad=%0d exp=13 bad=0", m_order, m_bad_data); end
        run_txns(4'b0001, 1);
        run_txns(4'b1001, 2);
        n_checks++; if (m_order != 41 || m_bad_data != 0) begin n_fail++; $display("FAIL rr_wrap_order got=%0d bad=%0d exp=41 bad=0", m_order, m_bad_data); end
        run_txns(4'b1000, 1);
        n_checks++; if (m_order != 4 || m_expired || m_q !== 64'd13) begin n_fail++; $display("FAIL rr_single3 got=%0d q=%0d exp=4 q=13", m_order, m_q); end
    endtask

    task automatic test_timeout();
        s_hang = 1'b1;
        set_tbl(2, 64'd1234, 32'd0, 64'd0, 32'd0);
        run_txns(4'b0100, 1);
        s_hang = 1'b0;
        n_checks++; if (m_n_flush != 1 || m_flush_lat != 18) begin n_fail++; $display("FAIL timeout_flush got=%0d@%0d exp=1@18", m_n_flush, m_flush_lat); end
        n_checks++; if (m_lat != 18 || m_rv !== 4'b0100) begin n_fail++; $display("FAIL timeout_rsp got=%0d/%b exp=18/0100", m_lat, m_rv); end
        n_checks++; if (m_tmo !== 1'b1 || m_ovf !== 1'b0) begin n_fail++; $display("FAIL timeout_status got=tmo%b ovf%b exp=1 0", m_tmo, m_ovf); end
        n_checks++; if (m_q !== 64'd0 || m_r !== 32'd0) begin n_fail++; $display("FAIL timeout_zero got=%0h/%0h exp=0/0", m_q, m_r); end
        set_tbl(0, 64'd100, 32'd7, 64'd14, 32'd2);
        run_txns(4'b0001, 1);
        n_checks++; if (m_q !== 64'd14 || m_r !== 32'd2 || m_tmo !== 1'b0 || m_n_flush != 0) begin n_fail++; $display("FAIL timeout_recover got=%0d/%0d tmo%b flush%0d exp=14/2 0 0", m_q, m_r, m_tmo, m_n_flush); end
    endtask

    task automatic test_timeout_edge();
        s_lat = 16;
        set_tbl(3, 64'd90, 32'd7, 64'd12, 32'd6);
        run_txns(4'b1000, 1);
        s_lat = 3;
        n_checks++; if (m_n_flush != 0 || m_tmo !== 1'b0) begin n_fail++; $display("FAIL edge_no_flush got=flush%0d tmo%b exp=0 0", m_n_flush, m_tmo); end
        n_checks++; if (m_q !== 64'd12 || m_r !== 32'd6 || m_lat != 18) begin n_fail++; $display("FAIL edge_result got=%0d/%0d lat%0d exp=12/6 lat18", m_q, m_r, m_lat); end
    endtask

    task automatic test_reset_mid_wait();
        int n_rsp_seen;
        set_tbl(1, 64'd60, 32'd4, 64'd15, 32'd0);
        set_tbl(2, 64'd70, 32'd5, 64'd14, 32'd0);
        s_lat = 10;
        @(negedge clk);
        req_dividend[1*DW +: DW] = t_dvd[1];
        req_divisor[1*VW +: VW]  = t_dvs[1];
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL midwait_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 4'h0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL midwait_rsp_clr got=%b/%0d exp=0000/0", rsp_valid, rsp_id); end
        n_checks++; if (rsp_quotient !== 64'd0 || rsp_remainder !== 32'd0 || rsp_timeout !== 1'b0 || rsp_overflow !== 1'b0) begin n_fail++; $display("FAIL midwait_result_clr got=%0h/%0h exp=0/0", rsp_quotient, rsp_remainder); end
        n_checks++; if (div_dividend !== 64'd0 || div_divisor !== 32'd0 || div_valid_in !== 1'b0 || div_flush !== 1'b0) begin n_fail++; $display("FAIL midwait_div_clr got=%0h/%0h exp=0/0", div_dividend, div_divisor); end
        n_rsp_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != '0) n_rsp_seen++;
        end
        n_checks++; if (n_rsp_seen != 0) begin n_fail++; $display("FAIL midwait_dropped got=%0d responses exp=0", n_rsp_seen); end
        s_lat = 3;
        run_txns(4'b0110, 2);
        n_checks++; if (m_order != 23) begin n_fail++; $display("FAIL midwait_rr_ptr got=%0d exp=23", m_order); end
        n_checks++; if (m_bad_data != 0 || m_expired || m_q !== 64'd14) begin n_fail++; $display("FAIL midwait_fresh got=bad%0d q=%0d exp=bad0 q=14", m_bad_data, m_q); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        test_reset();
        test_single();
        test_signed();
        test_divzero();
        test_round_robin();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
